hangman_main: RTL and testbench

Single-chip top of the two-keypad hangman game. It debounces a host keypad and a player keypad, builds a 5-letter secret word by multi-tap entry on the host side, and "transmits" it to the player side by locking it and raising `msg_sent`. It then scores player guesses and drives RGB status LEDs and four 16-character LCD row buffers (two for host, two for player).

---
 rtl/hangman_pkg.sv | 48 ++++
 rtl/key_debounce.sv | 59 +++++
 rtl/hangman_main.sv | 229 ++++++++++++++++++++++
 tb/tb_hangman_main.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// hangman_pkg: shared constants, state type and key-map helpers for the
// two-keypad hangman game.
//   WORD_LEN / MAX_MISSES  : game dimensions
//   hangman_state_e        : SETUP / PLAY / WIN / LOSE
//   KEY_*                  : 2-bit key codes produced by key_debounce
//   grp_base / grp_last    : first and last letter of each multi-tap group
package hangman_pkg;

    localparam int WORD_LEN   = 5;
    localparam int MAX_MISSES = 6;

    typedef enum logic [1:0] {SETUP, PLAY, WIN, LOSE} hangman_state_e;

    localparam logic [7:0] ASCII_SPACE      = 8'h20;
    localparam logic [7:0] ASCII_UNDERSCORE = 8'h5F;
    localparam logic [7:0] ASCII_ZERO       = 8'h30;
    localparam logic [7:0] ASCII_A          = 8'h41;

    // Key code equals the index of the one-hot row bit.
    localparam logic [1:0] KEY_SUBMIT = 2'd0;
    localparam logic [1:0] KEY_GRP_SZ = 2'd1;
    localparam logic [1:0] KEY_GRP_JR = 2'd2;
    localparam logic [1:0] KEY_GRP_AI = 2'd3;

    localparam logic [7:0] GRP_AI_BASE = 8'h41;  // 'A'
    localparam logic [7:0] GRP_AI_LAST = 8'h49;  // 'I'
    localparam logic [7:0] GRP_JR_BASE = 8'h4A;  // 'J'
    localparam logic [7:0] GRP_JR_LAST = 8'h52;  // 'R'
    localparam logic [7:0] GRP_SZ_BASE = 8'h53;  // 'S'
    localparam logic [7:0] GRP_SZ_LAST = 8'h5A;  // 'Z'

    function automatic logic [7:0] grp_base(input logic [1:0] k);
        case (k)
            KEY_GRP_AI: return GRP_AI_BASE;
            KEY_GRP_JR: return GRP_JR_BASE;
            default:    return GRP_SZ_BASE;
        endcase
    endfunction

    function automatic logic [7:0] grp_last(input logic [1:0] k);
        case (k)
            KEY_GRP_AI: return GRP_AI_LAST;
            KEY_GRP_JR: return GRP_JR_LAST;
            default:    return GRP_SZ_LAST;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchronizer, stability filter and single-shot key
// event for one 4-row keypad.
//   clk, nRst  : clock, asynchronous active-low reset
//   row        : raw keypad rows (one-hot when a key is pressed)
//   key_evt    : one-cycle pulse when a one-hot pattern has been stable for
//                DEBOUNCE cycles and the pad was seen idle since the last event
//   key_code   : index of the pressed row bit, valid with key_evt
module key_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [3:0] row,
    output logic       key_evt,
    output logic [1:0] key_code
);
    localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [3:0]    sync1, sync2, cand;
    logic [CW-1:0] cnt;
    logic          armed;
    logic          stable, one_hot;

    assign stable  = (sync2 == cand) && (cnt == CNT_MAX);
    assign one_hot = (cand != 4'd0) && ((cand & (cand - 4'd1)) == 4'd0);
    // armed is cleared on the edge after the event, so the pulse lasts one cycle.
    assign key_evt = stable && armed && one_hot;

    always_comb begin
        key_code = 2'd0;
        if (cand[3])      key_code = 2'd3;
        else if (cand[2]) key_code = 2'd2;
        else if (cand[1]) key_code = 2'd1;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1 <= 4'd0;
            sync2 <= 4'd0;
            cand  <= 4'd0;
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            sync1 <= row;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            // Multi-hot patterns neither fire nor re-arm.
            if (stable && cand == 4'd0) armed <= 1'b1;
            else if (key_evt)           armed <= 1'b0;
        end
    end

endmodule

// File: rtl/hangman_main.sv
// hangman_main: single-chip two-keypad hangman. Host builds a 5-letter word by
// multi-tap entry, locks it (msg_sent), then the player guesses letters.
//   clk, nRst               : clock, asynchronous active-low reset
//   role_switch             : 0 = host keypad active, 1 = player keypad active
//   input_row_host/_player  : keypad rows (bit0 SUBMIT, bit3 A-I, bit2 J-R, bit1 S-Z)
//   red, green, blue, error : status LEDs (blue = in SETUP)
//   msg_sent                : word locked and delivered to the player side
//   host_row1/2, play_row1/2: 16-char ASCII LCD rows, char 0 in [127:120]
// Optional macro HANGMAN_DUP_GUESS_CHECK_EN: reject repeated guesses in PLAY.
module hangman_main
    import hangman_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic         role_switch,
    input  logic [3:0]   input_row_host,
    input  logic [3:0]   input_row_player,
    output logic         red,
    output logic         green,
    output logic         blue,
    output logic         error,
    output logic         msg_sent,
    output logic [127:0] host_row1,
    output logic [127:0] host_row2,
    output logic [127:0] play_row1,
    output logic [127:0] play_row2
);
    localparam logic [127:0] BLANK = {16{ASCII_SPACE}};

    logic       host_evt, play_evt, evt;
    logic [1:0] host_code, play_code, code;

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_host_kp (
        .clk(clk), .nRst(nRst), .row(input_row_host),
        .key_evt(host_evt), .key_code(host_code));
    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_play_kp (
        .clk(clk), .nRst(nRst), .row(input_row_player),
        .key_evt(play_evt), .key_code(play_code));

    // Inactive keypad's events are simply not selected.
    assign evt  = role_switch ? play_evt  : host_evt;
    assign code = role_switch ? play_code : host_code;

    hangman_state_e              state, state_d;
    logic [WORD_LEN-1:0][7:0]    word, word_d;
    logic [2:0]                  len, len_d, misses, misses_d;
    logic                        pend_v, pend_v_d;
    logic [7:0]                  pend_c, pend_c_d;
    logic [1:0]                  pend_g, pend_g_d;
    logic [WORD_LEN-1:0]         revealed, revealed_d, hit_mask;
    logic                        red_d, green_d, error_d, sent_d, dup;
    logic [127:0]                h1_d, h2_d, p1_d, p2_d;

`ifdef HANGMAN_DUP_GUESS_CHECK_EN
    logic [25:0] guessed, guessed_d;
    logic [4:0]  gidx;
    assign gidx = 5'(pend_c - ASCII_A);
    assign dup  = guessed[gidx];
`else
    assign dup  = 1'b0;
`endif

    always_comb begin
        hit_mask = '0;
        for (int i = 0; i < WORD_LEN; i++) hit_mask[i] = (word[i] == pend_c);
    end

    always_comb begin
        state_d    = state;
        word_d     = word;
        len_d      = len;
        pend_v_d   = pend_v;
        pend_c_d   = pend_c;
        pend_g_d   = pend_g;
        revealed_d = revealed;
        misses_d   = misses;
        red_d      = red;
        green_d    = green;
        error_d    = error;
        sent_d     = msg_sent;
`ifdef HANGMAN_DUP_GUESS_CHECK_EN
        guessed_d  = guessed;
`endif
        if (evt) begin
            error_d = 1'b0;
            case (state)
                WIN, LOSE: begin
                    state_d    = SETUP;
                    word_d     = '0;
                    len_d      = 3'd0;
                    pend_v_d   = 1'b0;
                    pend_c_d   = 8'd0;
                    pend_g_d   = 2'd0;
                    revealed_d = '0;
                    misses_d   = 3'd0;
                    red_d      = 1'b0;
                    green_d    = 1'b0;
                    sent_d     = 1'b0;
`ifdef HANGMAN_DUP_GUESS_CHECK_EN
                    guessed_d  = '0;
`endif
                end
                default: begin
                    if (code != KEY_SUBMIT) begin
                        // Multi-tap: same group advances with wrap, new group restarts.
                        if (pend_v && pend_g == code)
                            pend_c_d = (pend_c == grp_last(code)) ? grp_base(code) : pend_c + 8'd1;
                        else
                            pend_c_d = grp_base(code);
                        pend_g_d = code;
                        pend_v_d = 1'b1;
                    end else if (state == SETUP) begin
                        if (pend_v) begin
                            pend_v_d = 1'b0;
                            if (len < 3'(WORD_LEN)) begin
                                word_d[len] = pend_c;
                                len_d       = len + 3'd1;
                            end else begin
                                error_d = 1'b1;
                            end
                        end else if (len == 3'(WORD_LEN)) begin
                            sent_d  = 1'b1;
                            state_d = PLAY;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else if (!pend_v) begin
                        error_d = 1'b1;
                    end else begin
                        pend_v_d = 1'b0;
                        if (dup) begin
                            error_d = 1'b1;
                        end else begin
`ifdef HANGMAN_DUP_GUESS_CHECK_EN
                            guessed_d[gidx] = 1'b1;
`endif
                            if (|hit_mask) begin
                                revealed_d = revealed | hit_mask;
                                green_d    = 1'b1;
                                red_d      = 1'b0;
                            end else begin
                                misses_d = misses + 3'd1;
                                red_d    = 1'b1;
                                green_d  = 1'b0;
                            end
                            if (revealed_d == '1)                   state_d = WIN;
                            else if (misses_d == 3'(MAX_MISSES))    state_d = LOSE;
                        end
                    end
                end
            endcase
        end
    end

    // Rows are formatted from next-state values so they register together
    // with the state they describe.
    always_comb begin
        h1_d = BLANK;
        h2_d = BLANK;
        p1_d = BLANK;
        p2_d = BLANK;
        h1_d[127:88] = "WORD:";
        for (int i = 0; i < WORD_LEN; i++)
            h1_d[8*(10-i) +: 8] = (3'(i) < len_d) ? word_d[i] : ASCII_UNDERSCORE;
        h2_d[127:96] = "KEY:";
        if (pend_v_d) h2_d[95:88] = pend_c_d;
        if (sent_d)   h2_d[79:48] = "SENT";
        if (sent_d) begin
            p1_d[127:80] = "GUESS:";
            for (int i = 0; i < WORD_LEN; i++)
                p1_d[8*(9-i) +: 8] = revealed_d[i] ? word_d[i] : ASCII_UNDERSCORE;
        end else begin
            p1_d[127:96] = "WAIT";
        end
        p2_d[127:88] = "MISS:";
        p2_d[87:80]  = ASCII_ZERO + {5'd0, misses_d};
        if (state_d == WIN)       p2_d[79:48] = " WIN";
        else if (state_d == LOSE) p2_d[79:40] = " LOSE";
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= SETUP;
            word      <= '0;
            len       <= 3'd0;
            pend_v    <= 1'b0;
            pend_c    <= 8'd0;
            pend_g    <= 2'd0;
            revealed  <= '0;
            misses    <= 3'd0;
            red       <= 1'b0;
            green     <= 1'b0;
            blue      <= 1'b1;
            error     <= 1'b0;
            msg_sent  <= 1'b0;
            host_row1 <= {"WORD:_____", {6{ASCII_SPACE}}};
            host_row2 <= {"KEY:", {12{ASCII_SPACE}}};
            play_row1 <= {"WAIT", {12{ASCII_SPACE}}};
            play_row2 <= {"MISS:0", {10{ASCII_SPACE}}};
`ifdef HANGMAN_DUP_GUESS_CHECK_EN
            guessed   <= '0;
`endif
        end else begin
            state     <= state_d;
            word      <= word_d;
            len       <= len_d;
            pend_v    <= pend_v_d;
            pend_c    <= pend_c_d;
            pend_g    <= pend_g_d;
            revealed  <= revealed_d;
            misses    <= misses_d;
            red       <= red_d;
            green     <= green_d;
            blue      <= (state_d == SETUP);
            error     <= error_d;
            msg_sent  <= sent_d;
            host_row1 <= h1_d;
            host_row2 <= h2_d;
            play_row1 <= p1_d;
            play_row2 <= p2_d;
`ifdef HANGMAN_DUP_GUESS_CHECK_EN
            guessed   <= guessed_d;
`endif
        end
    end

endmodule

// File: tb/tb_hangman_main.sv
// tb_hangman_main: scripted game sessions against hangman_main. Expected rows
// and LED vectors are queued after each key action and drained against the DUT.
module tb_hangman_main;
    localparam int DEB = 4;
    localparam int SEL_H1 = 0, SEL_H2 = 1, SEL_P1 = 2, SEL_P2 = 3, SEL_LED = 4;

    logic         tb_clk = 1'b0;
    logic         n_rst;
    logic         role_switch;
    logic [3:0]   row_host, row_player;
    logic         red, green, blue, error, msg_sent;
    logic [127:0] host_row1, host_row2, play_row1, play_row2;

    logic [127:0] exp_q[$];
    int           sel_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    hangman_main #(.DEBOUNCE(DEB)) dut (
        .clk(tb_clk), .nRst(n_rst), .role_switch(role_switch),
        .input_row_host(row_host), .input_row_player(row_player),
        .red(red), .green(green), .blue(blue), .error(error), .msg_sent(msg_sent),
        .host_row1(host_row1), .host_row2(host_row2),
        .play_row1(play_row1), .play_row2(play_row2));

    // clock / reset
    always #5 tb_clk = ~tb_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // checking
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h ('%s') want %h ('%s')", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [127:0] pad16(input string s);
        logic [127:0] r;
        r = {16{8'h20}};
        for (int i = 0; i < 16 && i < s.len(); i++) r[8*(15-i) +: 8] = s[i];
        return r;
    endfunction

    task automatic exp_row(input int sel, input string s);
        exp_q.push_back(pad16(s));
        sel_q.push_back(sel);
    endtask

    // LED vector order: {red, green, blue, error, msg_sent}
    task automatic exp_led(input logic [4:0] v);
        exp_q.push_back({123'd0, v});
        sel_q.push_back(SEL_LED);
    endtask

    task automatic drain(input string step);
        logic [127:0] e;
        int           s;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            s = sel_q.pop_front();
            case (s)
                SEL_H1:  check({step, ".host_row1"}, host_row1, e);
                SEL_H2:  check({step, ".host_row2"}, host_row2, e);
                SEL_P1:  check({step, ".play_row1"}, play_row1, e);
                SEL_P2:  check({step, ".play_row2"}, play_row2, e);
                default: check({step, ".leds"}, {123'd0, red, green, blue, error, msg_sent}, e);
            endcase
        end
    endtask

    task automatic exp_idle();
        exp_row(SEL_H1, "WORD:_____");
        exp_row(SEL_H2, "KEY:");
        exp_row(SEL_P1, "WAIT");
        exp_row(SEL_P2, "MISS:0");
        exp_led(5'b00100);
    endtask

    // drivers
    task automatic idle(input int n);
        repeat (n) @(negedge tb_clk);
    endtask

    task automatic press(input logic on_player, input logic role, input logic [3:0] bits);
        role_switch = role;
        if (on_player) row_player = bits;
        else           row_host   = bits;
        idle(DEB + 4 + int'($urandom_range(0, 3)));
        row_player = 4'd0;
        row_host   = 4'd0;
        idle(DEB + 4 + int'($urandom_range(0, 3)));
    endtask

    task automatic tap(input logic pl, input logic [3:0] bits, input int n);
        repeat (n) press(pl, pl, bits);
    endtask

    task automatic submit(input logic pl);
        press(pl, pl, 4'b0001);
    endtask

    // Multi-tap presses needed for a letter, from the key map.
    task automatic enter(input logic pl, input logic [7:0] c);
        if (c <= 8'h49)      tap(pl, 4'b1000, int'(c - 8'h41) + 1);
        else if (c <= 8'h52) tap(pl, 4'b0100, int'(c - 8'h4A) + 1);
        else                 tap(pl, 4'b0010, int'(c - 8'h53) + 1);
    endtask

    task automatic guess(input logic pl, input logic [7:0] c);
        enter(pl, c);
        submit(pl);
    endtask

    initial begin
        string miss_letters;
        int    m;
        n_rst = 1'b0;
        role_switch = 1'b0;
        row_host = 4'd0;
        row_player = 4'd0;
        idle(3);
        n_rst = 1'b1;
        idle(2 * DEB + 6);

        exp_idle();
        drain("reset");

        // Host setup: word AECIJ
        submit(0);
        exp_led(5'b00110);
        exp_row(SEL_H1, "WORD:_____");
        drain("empty_submit");
        enter(0, "A");
        exp_row(SEL_H2, "KEY:A");
        exp_led(5'b00100);
        drain("pend_a");
        submit(0);
        exp_row(SEL_H1, "WORD:A____");
        exp_row(SEL_H2, "KEY:");
        drain("append_a");
        enter(0, "E");
        exp_row(SEL_H2, "KEY:E");
        drain("pend_e");
        submit(0);
        guess(0, "C");
        enter(0, "I");
        exp_row(SEL_H2, "KEY:I");
        drain("pend_i");
        submit(0);
        guess(0, "J");
        exp_row(SEL_H1, "WORD:AECIJ");
        exp_led(5'b00100);
        drain("word_full");
        tap(0, 4'b0100, 10);
        exp_row(SEL_H2, "KEY:J");
        drain("wrap_r_j");
        submit(0);
        exp_led(5'b00110);
        exp_row(SEL_H2, "KEY:");
        exp_row(SEL_H1, "WORD:AECIJ");
        drain("sixth_letter");
        submit(0);
        exp_led(5'b00001);
        exp_row(SEL_H2, "KEY:  SENT");
        exp_row(SEL_P1, "GUESS:_____");
        exp_row(SEL_P2, "MISS:0");
        drain("lock");

        // Player round 1: hit, miss, errors, then lose
        guess(1, "A");
        exp_row(SEL_P1, "GUESS:A____");
        exp_led(5'b01001);
        drain("hit_a");
        guess(1, "S");
        exp_led(5'b10001);
        exp_row(SEL_P2, "MISS:1");
        drain("miss_s");
        submit(1);
        exp_led(5'b10011);
        drain("play_empty_submit");
        press(1, 1, 4'b1001);
        exp_led(5'b10011);
        exp_row(SEL_H2, "KEY:  SENT");
        drain("multi_hot");
        press(0, 1, 4'b1000);
        exp_led(5'b10011);
        exp_row(SEL_H2, "KEY:  SENT");
        drain("inactive_pad");
        miss_letters = "TUVWX";
        for (int k = 0; k < 5; k++) begin
            guess(1, miss_letters[k]);
            m = k + 2;
            if (m < 6) exp_row(SEL_P2, $sformatf("MISS:%0d", m));
            else       exp_row(SEL_P2, "MISS:6 LOSE");
            exp_led(5'b10001);
            drain($sformatf("miss_%0d", m));
        end
        exp_row(SEL_P1, "GUESS:A____");
        drain("lose_row1");
        press(1, 1, 4'b1000);
        exp_idle();
        drain("lose_clear");

        // Host setup: word HELLO
        guess(0, "H");
        guess(0, "E");
        guess(0, "L");
        exp_row(SEL_H1, "WORD:HEL__");
        drain("partial");
        guess(0, "L");
        guess(0, "O");
        submit(0);
        exp_row(SEL_H1, "WORD:HELLO");
        exp_led(5'b00001);
        drain("lock2");

        // Player round 2: repeats, then win
        guess(1, "L");
        exp_row(SEL_P1, "GUESS:__LL_");
        exp_led(5'b01001);
        drain("hit_ll");
        guess(1, "L");
`ifdef HANGMAN_DUP_GUESS_CHECK_EN
        exp_led(5'b01011);
`else
        exp_led(5'b01001);
`endif
        exp_row(SEL_P2, "MISS:0");
        drain("repeat_hit");
        guess(1, "Z");
        exp_row(SEL_P2, "MISS:1");
        exp_led(5'b10001);
        drain("miss_z");
        guess(1, "Z");
`ifdef HANGMAN_DUP_GUESS_CHECK_EN
        exp_row(SEL_P2, "MISS:1");
        exp_led(5'b10011);
`else
        exp_row(SEL_P2, "MISS:2");
        exp_led(5'b10001);
`endif
        drain("repeat_miss");
        guess(1, "H");
        guess(1, "E");
        guess(1, "O");
        exp_row(SEL_P1, "GUESS:HELLO");
`ifdef HANGMAN_DUP_GUESS_CHECK_EN
        exp_row(SEL_P2, "MISS:1 WIN");
`else
        exp_row(SEL_P2, "MISS:2 WIN");
`endif
        exp_led(5'b01001);
        drain("win");

        // Asynchronous reset from WIN, sampled before any clock edge
        #2;
        n_rst = 1'b0;
        #1;
        exp_idle();
        drain("async_reset");
        idle(2);
        n_rst = 1'b1;
        idle(2 * DEB + 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
